// File: rtl/obstacle_scheduler.sv
// Obstacle pool controller: per frame, moves active obstacles down the screen,
// retires those leaving the bottom edge, spawns new ones on a timer, latches game-over.
module obstacle_scheduler #(
  parameter int          N_OBS        = 4,
  parameter int          CORDW        = 16,
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter int          OBS_SIZE     = 40,
  parameter int          SPAWN_PERIOD = 60,
  parameter int          SPEED        = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                   clk_pix,
  input  logic                   rst,
  input  logic                   frame,
  input  logic                   en,
  input  logic                   collision,
  output logic [N_OBS*CORDW-1:0] obs_x,
  output logic [N_OBS*CORDW-1:0] obs_y,
  output logic [N_OBS-1:0]       obs_active,
  output logic [15:0]            score,
  output logic                   game_over,
  output logic                   busy
);

  localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam int TMR_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(N_OBS - 1);
  localparam logic [TMR_W-1:0]        TMR_RELOAD = TMR_W'(SPAWN_PERIOD - 1);
  localparam logic signed [CORDW-1:0] V_LIM      = CORDW'(V_RES);
  localparam logic signed [CORDW-1:0] STEP       = CORDW'(SPEED);
  localparam logic signed [CORDW-1:0] SPAWN_Y    = CORDW'(-OBS_SIZE);
  localparam logic [CORDW-1:0]        X_SPAN     = CORDW'(H_RES - OBS_SIZE);
  // Feedback mask for x^16+x^14+x^13+x^11 in a right-shifting Galois LFSR.
  localparam logic [15:0]             LFSR_MASK  = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SPAWN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [15:0]             score_q, score_d;
  logic                    go_q, go_d;
  logic signed [CORDW-1:0] x_q [N_OBS];
  logic signed [CORDW-1:0] x_d [N_OBS];
  logic signed [CORDW-1:0] y_q [N_OBS];
  logic signed [CORDW-1:0] y_d [N_OBS];
  logic [N_OBS-1:0]        act_q, act_d;

  logic [15:0]             lfsr_nxt;
  logic signed [CORDW-1:0] new_y;
  logic [CORDW-1:0]        r_ext;
  logic [IDX_W-1:0]        free_idx;
  logic                    free_found;

  assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & LFSR_MASK);

  // Descending scan so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_OBS - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    lfsr_d  = lfsr_q;
    score_d = score_q;
    go_d    = go_q;
    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    new_y   = y_q[idx_q] + STEP;
    r_ext   = CORDW'(lfsr_nxt[9:0]);

    unique case (state_q)
      S_IDLE: begin
        if (frame) begin
          if (collision) begin
            go_d = 1'b1;
          end else if (en && !go_q) begin
            state_d = S_MOVE;
            idx_d   = '0;
          end
        end
      end

      S_MOVE: begin
        if (act_q[idx_q]) begin
          if (new_y >= V_LIM) begin
            act_d[idx_q] = 1'b0;
            x_d[idx_q]   = '0;
            y_d[idx_q]   = '0;
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end else begin
            y_d[idx_q] = new_y;
          end
        end
        if (idx_q == LAST_IDX) state_d = S_SPAWN;
        else                   idx_d   = idx_q + IDX_W'(1);
      end

      S_SPAWN: begin
        lfsr_d  = lfsr_nxt;
        state_d = S_IDLE;
        if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          timer_d = TMR_RELOAD;
          // A full pool drops this spawn; the timer has reloaded regardless.
          if (free_found) begin
            act_d[free_idx] = 1'b1;
            y_d[free_idx]   = SPAWN_Y;
            x_d[free_idx]   = (r_ext < X_SPAN) ? r_ext : r_ext - X_SPAN;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= TMR_RELOAD;
      lfsr_q  <= LFSR_SEED;
      score_q <= '0;
      go_q    <= 1'b0;
      act_q   <= '0;
      // NOTE: the slot arrays are visible outputs, so they are reset rather than left as plain storage.
      for (int i = 0; i < N_OBS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      go_q    <= go_d;
      act_q   <= act_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  for (genvar g = 0; g < N_OBS; g++) begin : g_pack
    assign obs_x[g*CORDW +: CORDW] = x_q[g];
    assign obs_y[g*CORDW +: CORDW] = y_q[g];
  end

  assign obs_active = act_q;
  assign score      = score_q;
  assign game_over  = go_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: randomized frame/enable stimulus against a
// frame-level reference model, plus directed spawn, retire/refill, collision and reset steps.
module tb_obstacle_scheduler;

  localparam int          N    = 2;
  localparam int          CW   = 16;
  localparam int          HR   = 640;
  localparam int          VR   = 480;
  localparam int          OS   = 40;
  localparam int          PER  = 4;
  localparam int          SPD  = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk_pix = 1'b0;
  logic          rst = 1'b0;
  logic          frame = 1'b0;
  logic          en = 1'b0;
  logic          collision = 1'b0;
  logic [N*CW-1:0] obs_x, obs_y;
  logic [N-1:0]  obs_active;
  logic [15:0]   score;
  logic          game_over, busy;

  obstacle_scheduler #(
    .N_OBS(N), .CORDW(CW), .H_RES(HR), .V_RES(VR), .OBS_SIZE(OS),
    .SPAWN_PERIOD(PER), .SPEED(SPD), .LFSR_SEED(SEED)
  ) dut (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .en(en), .collision(collision),
    .obs_x(obs_x), .obs_y(obs_y), .obs_active(obs_active),
    .score(score), .game_over(game_over), .busy(busy)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int failures = 0;

  // Frame-level reference model state.
  int          m_x [N];
  int          m_y [N];
  bit          m_act [N];
  int          m_score;
  int          m_timer;
  logic [15:0] m_lfsr;
  bit          m_go;
  int          processed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] poly_step(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'b1011_0100_0000_0000;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_act[i] = 0;
    end
    m_score = 0; m_timer = PER - 1; m_lfsr = SEED; m_go = 0; processed = 0;
  endtask

  task automatic model_step();
    int r;
    int slot;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (m_y[i] + SPD >= VR) begin
          m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
          if (m_score < 65535) m_score++;
        end else begin
          m_y[i] = m_y[i] + SPD;
        end
      end
    end
    m_lfsr = poly_step(m_lfsr);
    if (m_timer > 0) begin
      m_timer--;
    end else begin
      m_timer = PER - 1;
      slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
      if (slot >= 0) begin
        r = int'(m_lfsr[9:0]);
        m_act[slot] = 1;
        m_y[slot]   = -OS;
        m_x[slot]   = (r < HR - OS) ? r : r - (HR - OS);
      end
    end
    processed++;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_x%0d", tag, i), 64'(obs_x[i*CW +: CW]), 64'(m_x[i]));
      check($sformatf("%s_y%0d", tag, i), 64'($signed(obs_y[i*CW +: CW])), 64'(m_y[i]));
      check($sformatf("%s_a%0d", tag, i), 64'(obs_active[i]), 64'(m_act[i]));
    end
    check({tag, "_score"}, 64'(score), 64'(m_score));
    check({tag, "_go"}, 64'(game_over), 64'(m_go));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // One frame pulse; checks the busy window cycle by cycle and then all outputs.
  task automatic do_frame(input bit en_i, input bit coll_i);
    bit proc;
    @(negedge clk_pix);
    frame = 1'b1; en = en_i; collision = coll_i;
    @(negedge clk_pix);
    frame = 1'b0; collision = 1'b0;
    proc = !coll_i && en_i && !m_go;
    if (coll_i) m_go = 1;
    else if (proc) model_step();
    check("go_now", 64'(game_over), 64'(m_go));
    for (int c = 0; c <= N; c++) begin
      check("busy_win", 64'(busy), 64'(proc));
      @(negedge clk_pix);
    end
    check_all("frame");
  endtask

  initial begin
    int iter;
    model_reset();

    // Reset state.
    #1 rst = 1'b1;
    #12;
    check_all("reset");
    @(negedge clk_pix) rst = 1'b0;

    // First spawn lands on the 4th processed frame.
    for (int k = 0; k < PER; k++) do_frame(1'b1, 1'b0);
    check("first_act", 64'(obs_active), 64'(2'b01));
    check("first_y", 64'($signed(obs_y[CW-1:0])), 64'(-OS));
    check("first_x_rng", 64'(obs_x[CW-1:0] < 16'(HR - OS)), 64'(1));

    // Randomized enable/gaps until past the first retire + refill frame.
    iter = 0;
    while (processed < 275 && iter < 500) begin
      do_frame(($urandom_range(0, 7) != 0), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk_pix);
      if (processed == 12) check("pool_full", 64'(obs_active), 64'(2'b11));
      if (processed == 263) check("y0_edge", 64'($signed(obs_y[CW-1:0])), 64'(478));
      if (processed == 264) begin
        check("refill_score", 64'(score), 64'(1));
        check("refill_act", 64'(obs_active[0]), 64'(1));
        check("refill_y", 64'($signed(obs_y[CW-1:0])), 64'(-OS));
      end
      iter++;
    end
    check("random_done", 64'(processed >= 275), 64'(1));

    // en=0 frames change nothing.
    repeat (3) do_frame(1'b0, 1'b0);

    // Collision latches game-over and freezes the pool.
    do_frame(1'b1, 1'b1);
    check("go_set", 64'(game_over), 64'(1));
    repeat (10) do_frame(1'b1, 1'b0);

    // Reset clears game-over.
    @(negedge clk_pix) rst = 1'b1;
    #1 model_reset();
    check_all("rst_go");
    @(negedge clk_pix) rst = 1'b0;

    // Reset in the middle of MOVE cycle 1.
    repeat (5) do_frame(1'b1, 1'b0);
    @(negedge clk_pix);
    frame = 1'b1; en = 1'b1;
    @(negedge clk_pix);
    frame = 1'b0;
    check("mid_busy", 64'(busy), 64'(1));
    @(posedge clk_pix);
    #3 rst = 1'b1;
    #1 model_reset();
    check_all("mid_rst");
    @(negedge clk_pix) rst = 1'b0;
    // Timer and LFSR restarted: the first spawn repeats the seeded position.
    for (int k = 0; k < PER; k++) do_frame(1'b1, 1'b0);
    check("respawn_act", 64'(obs_active), 64'(2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Frame-rate controller that owns the obstacle pool for the game screen. Each frame it advances every active obstacle down the screen, retires obstacles that leave the bottom edge, and spawns new ones at pseudo-random x positions on a fixed frame interval. It latches game-over on collision. Its packed position and active outputs drive one `sprite` instance per slot; it runs in the `clk_pix` domain alongside `display_480p`.

## Interface
Parameters:
- N_OBS, 4: number of obstacle slots (1–8).
- CORDW, 16: signed screen-coordinate width.
- H_RES, 640: horizontal resolution.
- V_RES, 480: vertical resolution.
- OBS_SIZE, 40: on-screen obstacle edge in pixels (sprite WIDTH×SCALE).
- SPAWN_PERIOD, 60: frames between spawn attempts (≥1).
- SPEED, 2: pixels moved per frame (≥1).
- LFSR_SEED, 16'hACE1: LFSR reset value (non-zero).

Ports:
- clk_pix  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- frame  in  1  one-cycle pulse at frame start (from `display_480p`).
- en  in  1  run enable, sampled on `frame`.
- collision  in  1  per-frame collision flag, sampled on `frame`.
- obs_x  out  N_OBS*CORDW  packed signed x; slot i occupies bits [i*CORDW +: CORDW].
- obs_y  out  N_OBS*CORDW  packed signed y, same packing.
- obs_active  out  N_OBS  slot i is valid and drawn.
- score  out  16  count of retired obstacles; saturates at 16'hFFFF.
- game_over  out  1  sticky collision flag.
- busy  out  1  high while a frame update is in progress.

## Operation
- Reset values (immediate on rst, including mid-update):
  - All obs_x, obs_y, obs_active, score, game_over, and busy = 0.
  - State = IDLE, slot index = 0.
  - Spawn timer = SPAWN_PERIOD-1.
  - LFSR = LFSR_SEED.
- FSM states: IDLE, MOVE, SPAWN.
  - IDLE: on `frame`:
    - If collision=1: set game_over and stay in IDLE.
    - Else, if en=1 and game_over=0: go to MOVE with idx=0 and busy=1.
    - Otherwise the frame is ignored.
  - MOVE: handles one slot per cycle, idx 0..N_OBS-1.
    - For an active slot, new_y = obs_y + SPEED (signed, CORDW bits).
    - If new_y ≥ V_RES: clear the slot (active=0, x=y=0) and increment score (saturating).
    - Else: obs_y = new_y.
    - Inactive slots are untouched.
    - After idx = N_OBS-1, go to SPAWN.
  - SPAWN: single cycle.
    - The LFSR advances exactly once per processed frame: 16-bit Galois, taps x^16+x^14+x^13+x^11.
    - If timer ≠ 0: decrement the timer.
    - If timer = 0: reload SPAWN_PERIOD-1, then pick the lowest-index inactive slot.
    - That slot gets obs_active=1 and obs_y = -OBS_SIZE.
    - Its obs_x comes from r = lfsr[9:0] (the post-advance value): if r < H_RES-OBS_SIZE, x = r; else x = r - (H_RES-OBS_SIZE).
    - If no slot is free, the spawn is dropped; the timer still reloads.
    - Then go to IDLE with busy=0.
- A slot retired in MOVE can be refilled in the same frame's SPAWN.
- A newly spawned obstacle is not moved in its spawn frame.
- game_over freezes all outputs except busy (which stays 0). Only rst clears it.
- en=0 freezes the timer, LFSR, and positions.

## Timing
- frame → busy rises the next cycle.
- busy is high for exactly N_OBS+1 cycles (N MOVE cycles plus 1 SPAWN).
- Outputs are final on the cycle busy falls, well inside vertical blanking.
- Slot i's obs_y updates registered at MOVE cycle i+1 after frame.
- Spawn outputs are registered at the end of the SPAWN cycle.
- A `frame` pulse while busy=1 is ignored; it cannot occur at 640×480 timing.
- collision → game_over = 1 one cycle after the sampling `frame`.
- No combinational path from any input to any output.

## Test plan
- Reset and first spawn:
  - Setup: N_OBS=2, SPAWN_PERIOD=4, en=1. Assert rst, release, apply 4 frame pulses.
  - Expected: all outputs 0 until the 4th frame. After it, obs_active=2'b01, slot0 y=-40, x∈[0,599] and equal to the model-LFSR value, busy high for 3 cycles per frame.
- Movement and retirement:
  - Setup: SPEED=2, SPAWN_PERIOD=1000. After the first spawn, slot0 y = -40+2k after k frames.
  - Expected: at k=260, obs_active[0]=0, x=y=0, score=1.
- Pool full:
  - Setup: N_OBS=2, SPAWN_PERIOD=1, SPEED=1.
  - Expected: frames 1–2 fill slots 0 and 1. Frame 3 spawn is dropped: obs_active stays 2'b11 and the slot positions do not change.
- Same-frame retire and refill:
  - Setup: slot0 at y=478 with SPEED=2, spawn due that frame.
  - Expected: slot0 retires (score+1) and is respawned at y=-40 within one busy window.
- Collision and enable:
  - Step 1: collision=1 at a frame. Expected: game_over=1, busy stays 0, positions frozen over 10 further frames.
  - Step 2: with en=0 instead of a collision. Expected: no state change.
  - Step 3: rst. Expected: clears game_over.
- Reset mid-update:
  - Stimulus: assert rst during MOVE cycle 1 (asynchronous, mid-cycle).
  - Expected: busy=0, all outputs 0, and timer/LFSR at reset values immediately.
